pipe_cla_adder: RTL and testbench
=================================

Name: pipe_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the 4-bit registered CLA wrapper: operand width is generalised, and the carry chain is split into BLOCK-bit lookahead groups, with one group per pipeline stage. It adds a valid/ready handshake with backpressure, a subtract mode, and synchronous reset. It sits between operand-producing logic and any consumer that needs a WIDTH-bit sum and carry.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of BLOCK.
BLOCK, 4, bits per lookahead group; legal range 1..8.
NSTG, WIDTH/BLOCK (derived localparam), number of carry stages.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in for add; borrow-in for subtract.
in_sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts the result.
out_sum  output  WIDTH  result modulo 2^WIDTH.
out_cout  output  1  carry-out for add; not-borrow for subtract.
out_ovf  output  1  signed overflow; present only with PIPE_CLA_OVF_EN.

Behaviour:
- Arithmetic:
  - Add: out_sum/out_cout = in_a + in_b + in_cin.
  - Subtract: result = in_a + ~in_b + ~in_cin, i.e. A - B - borrow_in. out_cout = 1 means no borrow.
- Pipeline structure:
  - Stage 0 registers in_a, in_b (inverted when in_sub = 1), the effective carry-in, and the valid bit.
  - Stage k (1..NSTG) computes group k-1 using group-level generate/propagate lookahead. It registers that group's sum bits, the group carry-out, and the still-unprocessed upper operand bits.
  - out_* are driven directly from stage NSTG registers.
- Latency: NSTG+1 cycles from an accepted beat to out_valid (5 cycles at the defaults). Throughput is 1 beat/cycle.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - Global advance: adv = !out_valid || out_ready, and in_ready = adv (combinational). When adv = 0 every stage holds.
  - Bubbles are not collapsed.
  - in_valid while in_ready = 0 is ignored; the upstream holds the beat.
- out_* are stable while out_valid && !out_ready.
- Reset, while rst = 1:
  - All stage valid bits, out_valid, out_sum, out_cout and out_ovf clear to 0.
  - in_ready = 1 in the cycle after rst is released.
  - Reset mid-operation discards every in-flight beat; none are ever presented.
- Simultaneous accept and consume in the same cycle is legal and keeps full throughput.
- Wrap-around: the sum wraps modulo 2^WIDTH and the carry appears only on out_cout.
- Illegal parameters (WIDTH % BLOCK != 0, or BLOCK outside 1..8) raise an elaboration-time error.

Optional Feature:
PIPE_CLA_OVF_EN:
- Defined: the out_ovf port exists. out_ovf = carry into the MSB XOR carry out of the MSB, computed in stage NSTG, valid with out_valid, reset to 0.
- Undefined: the out_ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_cla_pkg holds:
  - BLOCK_DEFAULT constant.
  - Op encoding constants OP_ADD = 0 and OP_SUB = 1.
  - A function computing NSTG.
- One sub-module, cla_group: a combinational BLOCK-bit lookahead group. Inputs a, b, cin; outputs sum, cout, group P, group G. It is instantiated once per stage by a generate loop.

Test Plan (WIDTH=16, BLOCK=4):
1. Hold rst for 2 cycles, then release -> out_valid = 0, out_sum = 0x0000, out_cout = 0, in_ready = 1.
2. Add A=0xFFFF, B=0x0001, cin=0 -> 5 cycles later out_sum = 0x0000, out_cout = 1 (carry ripples across all 4 groups).
3. Subtract A=0x0005, B=0x0007, cin=0 -> out_sum = 0xFFFE, out_cout = 0 (borrow). Subtract A=0x0010, B=0x0001, cin=1 -> out_sum = 0x000E, out_cout = 1.
4. Stream 8 back-to-back random beats; drop out_ready for 3 cycles once the first result appears -> in_ready is low for exactly those cycles, all 8 results match the model in order, and none are lost or duplicated.
5. Accept 3 beats, assert rst for 1 cycle mid-flight -> no result is ever presented. A new beat A=0x1234, B=0x4321 then produces 0x5555 after 5 cycles.
6. With PIPE_CLA_OVF_EN: add 0x7FFF + 0x0001 -> out_sum = 0x8000, out_ovf = 1. Add 0x0001 + 0x0001 -> out_ovf = 0. Without the macro, the build has no out_ovf port.

Source files
------------

// File: rtl/pipe_cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Holds the default group width, the add/subtract op encoding and the stage-count function.
package pipe_cla_pkg;

    localparam int   BLOCK_DEFAULT = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int calc_nstg(input int width, input int block);
        return (block > 0) ? (width / block) : 1;
    endfunction

endpackage

// File: rtl/pipe_cla_adder_cla_group.sv
// cla_group: combinational BLOCK-bit carry-lookahead group with group propagate/generate.
// Purely combinational; the enclosing pipeline registers its outputs.
module cla_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             p,
    output logic             g
);

    logic [BLOCK-1:0] gi;
    logic [BLOCK-1:0] pi;
    logic [BLOCK-1:0] c;

    always_comb begin
        gi   = a & b;
        pi   = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK - 1; i++) begin
            c[i+1] = gi[i] | (pi[i] & c[i]);
        end
        sum = pi ^ c;
        // group generate folds from LSB upward so higher bits dominate
        p = &pi;
        g = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            g = gi[i] | (pi[i] & g);
        end
        cout = g | (p & cin);
    end

endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: pipelined CLA adder/subtractor, one BLOCK-bit lookahead group per stage.
// Define PIPE_CLA_OVF_EN to add the out_ovf signed-overflow output.
module pipe_cla_adder
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = BLOCK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef PIPE_CLA_OVF_EN
    output logic             out_cout,
    output logic             out_ovf
`else
    output logic             out_cout
`endif
);

    localparam int NSTG = calc_nstg(WIDTH, BLOCK);
    localparam int BTOT = BLOCK * NSTG * (NSTG + 1) / 2;

    if (BLOCK < 1 || BLOCK > 8 || (WIDTH % BLOCK) != 0) begin : g_bad_param
        $error("pipe_cla_adder: BLOCK must be 1..8 and WIDTH a multiple of BLOCK");
    end

    // Pending B bits shrink by one group per stage, so they live in one packed triangle.
    function automatic int b_off(input int k);
        return BLOCK * (k * NSTG - (k * (k - 1)) / 2);
    endfunction

    logic                       adv;
    logic [NSTG:0][WIDTH-1:0]   x_q, x_d;
    logic [BTOT-1:0]            b_q, b_d;
    logic [NSTG:0]              c_q, c_d;
    logic [NSTG:0]              v_q, v_d;
    logic [WIDTH-1:0]           b_eff;
    logic                       c_eff;

    assign adv       = ~v_q[NSTG] | out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[NSTG];
    assign out_sum   = x_q[NSTG];
    assign out_cout  = c_q[NSTG];

    always_comb begin
        b_eff = in_b;
        c_eff = in_cin;
        case (in_sub)
            OP_ADD: begin
                b_eff = in_b;
                c_eff = in_cin;
            end
            OP_SUB: begin
                b_eff = ~in_b;
                c_eff = ~in_cin;
            end
        endcase
    end

    assign x_d[0]          = in_a;
    assign b_d[WIDTH-1:0]  = b_eff;
    assign c_d[0]          = c_eff;
    assign v_d             = {v_q[NSTG-1:0], in_valid};

`ifdef PIPE_CLA_OVF_EN
    logic ovf_d, ovf_q;
    assign out_ovf = ovf_q;
`endif

    // x rotates right by one group per stage: pending A bits low, finished sum bits high.
    for (genvar k = 1; k <= NSTG; k++) begin : g_stg
        localparam int BP = b_off(k - 1);
        logic [BLOCK-1:0] grp_sum;
        logic             grp_cout, grp_p, grp_g;

        cla_group #(.BLOCK(BLOCK)) u_grp (
            .a    (x_q[k-1][BLOCK-1:0]),
            .b    (b_q[BP +: BLOCK]),
            .cin  (c_q[k-1]),
            .sum  (grp_sum),
            .cout (grp_cout),
            .p    (grp_p),
            .g    (grp_g)
        );

        if (BLOCK == WIDTH) begin : g_one
            assign x_d[k] = grp_sum;
        end else begin : g_rot
            assign x_d[k] = {grp_sum, x_q[k-1][WIDTH-1:BLOCK]};
        end

        assign c_d[k] = grp_cout;

        if (k < NSTG) begin : g_bpass
            localparam int BW = (NSTG - k) * BLOCK;
            assign b_d[b_off(k) +: BW] = b_q[BP + BLOCK +: BW];
        end

        always_comb begin
            if (!rst) assert (grp_cout == (grp_g | (grp_p & c_q[k-1])));
        end

`ifdef PIPE_CLA_OVF_EN
        if (k == NSTG) begin : g_ovf
            assign ovf_d = x_q[k-1][BLOCK-1] ^ b_q[BP + BLOCK - 1] ^ grp_sum[BLOCK-1] ^ grp_cout;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            x_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (adv) begin
            v_q <= v_d;
            x_q <= x_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

`ifdef PIPE_CLA_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder (WIDTH=16, BLOCK=4) with hand-computed directed vectors.
// Drives at posedge+1, samples at negedge; out_ovf is checked only when PIPE_CLA_OVF_EN is defined.
module tb_pipe_cla_adder;

    localparam int WIDTH = 16;
    localparam int LAT   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef PIPE_CLA_OVF_EN
    logic             out_ovf;
`endif

    pipe_cla_adder #(.WIDTH(WIDTH), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef PIPE_CLA_OVF_EN
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
`else
        .out_cout  (out_cout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc;
        bit               chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   cnt_en = 0;
    int   stall_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: pops the scoreboard on every consumed result, checks hold-stability during stalls
    initial begin
        logic [WIDTH-1:0] held_sum;
        logic             held_cout;
        bit               held;
        exp_t             e;
        held = 0;
        held_sum = '0;
        held_cout = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cnt_en && !in_ready) stall_cnt++;
                if (held) begin
                    check("stall_hold_valid", out_valid, 1);
                    check("stall_hold_sum", out_sum, held_sum);
                    check("stall_hold_cout", out_cout, held_cout);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result: got sum 0x%0h with no beat outstanding", out_sum);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_sum", out_sum, e.sum);
                        check("result_cout", out_cout, e.cout);
                        if (e.chk_lat) check("result_latency", cyc - e.acc, LAT);
`ifdef PIPE_CLA_OVF_EN
                        check("result_ovf", out_ovf, e.ovf);
`endif
                    end
                end
                held      = out_valid && !out_ready;
                held_sum  = out_sum;
                held_cout = out_cout;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub,
                        input logic [WIDTH-1:0] s, input logic co, input logic ov,
                        input bit lat);
        int   waited;
        exp_t e;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end else begin
            e.sum     = s;
            e.cout    = co;
            e.ovf     = ov;
            e.acc     = cyc;
            e.chk_lat = lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain_outstanding", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sum", out_sum, 16'h0000);
        check("reset_out_cout", out_cout, 0);
        check("reset_in_ready", in_ready, 1);
        mon_en = 1;
        @(posedge clk);
        #1;

        // 2: carry ripples through all four groups
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        drain();

        // 3: subtract with borrow out, then with borrow in
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
        send(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1);
        drain();

        // 4: eight back-to-back beats with a 3-cycle consumer stall
        stall_cnt = 0;
        cnt_en    = 1;
        fork
            begin
                send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 0);
                send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
                send(16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0, 0);
                send(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0);
                send(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0, 0);
                send(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0);
                send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
                send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
            end
            begin
                int w;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!out_valid && w < 100);
                check("stall_first_valid", out_valid, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("unstall_in_ready", in_ready, 1);
            end
        join
        drain();
        cnt_en = 0;
        check("stall_cycle_count", stall_cnt, 3);

        // 5: reset mid-flight discards in-flight beats
        send(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0, 1);
        send(16'h0404, 16'h0505, 1'b0, 1'b0, 16'h0909, 1'b0, 1'b0, 1);
        send(16'h0606, 16'h0707, 1'b0, 1'b0, 16'h0D0D, 1'b0, 1'b0, 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_output", seen, 0);
        @(posedge clk);
        #1;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1);
        drain();

        // 6: signed-overflow vectors (out_ovf checked only when the port exists)
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
